// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the game RAM arbiter
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] FRET_TABLE_BASE = 16'hF000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_FB   = 2'd2
    } tag_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - IDLE-state winner select; MEM_ARB_FAIR_EN adds the round-robin pointer
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_FAIR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic arb_en_i,
    input  logic cpu_req_i,
    input  logic fb_req_i,
    output logic gnt_cpu_o,
    output logic gnt_fb_o
);

`ifdef MEM_ARB_FAIR_EN
    // Set when the fetcher should win the next contested cycle.
    logic prio_fb_q, prio_fb_d;

    always_comb begin
        gnt_cpu_o = 1'b0;
        gnt_fb_o  = 1'b0;
        if (arb_en_i) begin
            if (cpu_req_i && !(fb_req_i && prio_fb_q)) begin
                gnt_cpu_o = 1'b1;
            end else if (fb_req_i) begin
                gnt_fb_o = 1'b1;
            end
        end
    end

    always_comb begin
        prio_fb_d = prio_fb_q;
        if (gnt_cpu_o) begin
            prio_fb_d = 1'b1;
        end else if (gnt_fb_o) begin
            prio_fb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_fb_q <= 1'b0;
        end else begin
            prio_fb_q <= prio_fb_d;
        end
    end
`else
    always_comb begin
        gnt_cpu_o = arb_en_i && cpu_req_i;
        gnt_fb_o  = arb_en_i && fb_req_i && !cpu_req_i;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU / burst-fetcher arbiter for the single-port game RAM
// Define MEM_ARB_FAIR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 32,
    parameter int LEN_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fb_req,
    input  logic [ADDR_W-1:0] fb_addr,
    input  logic [LEN_W-1:0]  fb_len,
    output logic              fb_gnt,
    output logic              fb_rvalid,
    output logic [DATA_W-1:0] fb_rdata,
    output logic              fb_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    tag_e               tag_q, tag_d;
    logic               last_q, last_d;

    logic               arb_en;
    logic               pick_cpu;
    logic               pick_fb;
    logic [LEN_W-1:0]   len_eff;

    // Reset gates arbitration so a request in the reset cycle is never granted.
    assign arb_en = reset && (state_q == ST_IDLE);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_FAIR_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .arb_en_i  (arb_en),
        .cpu_req_i (cpu_req),
        .fb_req_i  (fb_req),
        .gnt_cpu_o (pick_cpu),
        .gnt_fb_o  (pick_fb)
    );

    always_comb begin
        if (fb_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (fb_len > LEN_W'(BURST_MAX)) begin
            len_eff = LEN_W'(BURST_MAX);
        end else begin
            len_eff = fb_len;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tag_d     = TAG_NONE;
        last_d    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_cpu) begin
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    tag_d     = cpu_we ? TAG_NONE : TAG_CPU;
                end else if (pick_fb) begin
                    mem_addr = fb_addr;
                    tag_d    = TAG_FB;
                    if (len_eff == LEN_W'(1)) begin
                        last_d = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        addr_d  = fb_addr + 16'd1;
                        cnt_d   = len_eff - LEN_W'(1);
                    end
                end
            end
            ST_BURST: begin
                if (reset) begin
                    mem_addr = addr_q;
                    tag_d    = TAG_FB;
                    addr_d   = addr_q + 16'd1;
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        last_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            tag_q   <= TAG_NONE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
        end
    end

    // Return-side outputs are also masked during reset so an in-flight read is dropped.
    assign cpu_gnt    = pick_cpu;
    assign fb_gnt     = pick_fb;
    assign cpu_rvalid = reset && (tag_q == TAG_CPU);
    assign fb_rvalid  = reset && (tag_q == TAG_FB);
    assign fb_done    = fb_rvalid && last_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign fb_rdata   = fb_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a RAM model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        fb_req;
    logic [15:0] fb_addr;
    logic [5:0]  fb_len;
    logic        fb_gnt, fb_rvalid, fb_done;
    logic [15:0] fb_rdata;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .fb_req     (fb_req),
        .fb_addr    (fb_addr),
        .fb_len     (fb_len),
        .fb_gnt     (fb_gnt),
        .fb_rvalid  (fb_rvalid),
        .fb_rdata   (fb_rdata),
        .fb_done    (fb_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic any_out;
    assign any_out = |{cpu_gnt, cpu_rvalid, cpu_rdata, fb_gnt, fb_rvalid, fb_rdata,
                       fb_done, mem_we, mem_addr, mem_wdata};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fb_req = 1'b0; fb_addr = '0; fb_len = '0;
    endtask

    logic [15:0] fret [0:3];
`ifdef MEM_ARB_FAIR_EN
    logic [4:0] exp_cpu = 5'b01001;
    logic [4:0] exp_fb  = 5'b10010;
`else
    logic [4:0] exp_cpu = 5'b11111;
    logic [4:0] exp_fb  = 5'b00000;
`endif

    initial begin
        int done_at;
        fret[0] = 16'h0064; fret[1] = 16'h41F4; fret[2] = 16'h41F4; fret[3] = 16'h41F4;

        // reset with both requests present: nothing may be granted
        reset = 1'b0;
        idle_inputs();
        cpu_req = 1'b1; fb_req = 1'b1; fb_addr = 16'h1234; fb_len = 6'd4;
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset_outputs_zero", 32'(any_out), 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        for (int k = 0; k < 4; k++) preload(16'hF000 + 16'(k), fret[k]);
        for (int k = 0; k < 8; k++) preload(16'h0100 + 16'(k), 16'hA000 + 16'(k));
        preload(16'hFFFE, 16'hBEE0);
        preload(16'hFFFF, 16'hBEE1);
        preload(16'h0000, 16'hBEE2);
        @(negedge clk); idle_inputs();

        // CPU write then read back
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234; #1;
        chk("cpu_wr_gnt", 32'(cpu_gnt), 32'd1);
        chk("cpu_wr_bus", {15'd0, mem_we, mem_addr}, {15'd0, 1'b1, 16'h0010});
        chk("cpu_wr_data", 32'(mem_wdata), 32'h1234);
        @(negedge clk);
        cpu_we = 1'b0; cpu_wdata = 16'h0; #1;
        chk("cpu_rd_gnt", 32'(cpu_gnt), 32'd1);
        chk("cpu_wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge clk);
        idle_inputs(); #1;
        chk("cpu_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("cpu_rd_data", 32'(cpu_rdata), 32'h1234);
        chk("cpu_no_fb", 32'({fb_gnt, fb_rvalid, fb_done}), 32'd0);
        chk("idle_bus_zero", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);

        // 4-word fret table burst
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'hF000; fb_len = 6'd4; #1;
        chk("fret_gnt", 32'(fb_gnt), 32'd1);
        chk("fret_addr0", 32'(mem_addr), 32'hF000);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            idle_inputs(); #1;
            chk("fret_rvalid", 32'(fb_rvalid), 32'd1);
            chk("fret_rdata", 32'(fb_rdata), 32'(fret[i-1]));
            chk("fret_done", 32'(fb_done), (i == 4) ? 32'd1 : 32'd0);
            chk("fret_we", 32'(mem_we), 32'd0);
            if (i < 4) chk("fret_addr", 32'(mem_addr), 32'hF000 + 32'(i));
        end

        // CPU request arriving during an 8-word burst waits
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'h0100; fb_len = 6'd8; #1;
        chk("b8_gnt", 32'(fb_gnt), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            fb_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; #1;
            chk("b8_cpu_blocked", 32'(cpu_gnt), 32'd0);
            chk("b8_addr", 32'(mem_addr), 32'h0100 + 32'(i));
            chk("b8_rdata", 32'(fb_rdata), 32'hA000 + 32'(i - 1));
        end
        @(negedge clk); #1;
        chk("b8_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("b8_done", 32'(fb_done), 32'd1);
        chk("b8_last_rdata", 32'(fb_rdata), 32'hA007);
        @(negedge clk);
        idle_inputs(); #1;
        chk("b8_cpu_rvalid", 32'({cpu_rvalid, cpu_rdata}), {15'd0, 1'b1, 16'h1234});

        // both ports request continuously, starting from a fresh pointer
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
            fb_req = 1'b1; fb_addr = 16'h0100; fb_len = 6'd2; #1;
            chk("both_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu[c]));
            chk("both_fb_gnt", 32'(fb_gnt), 32'(exp_fb[c]));
        end
        @(negedge clk); idle_inputs();
        repeat (3) @(negedge clk);

        // address wrap at the top of memory
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'hFFFE; fb_len = 6'd3; #1;
        chk("wrap_addr0", 32'(mem_addr), 32'hFFFE);
        @(negedge clk); idle_inputs(); #1;
        chk("wrap_addr1", 32'(mem_addr), 32'hFFFF);
        @(negedge clk); #1;
        chk("wrap_addr2", 32'(mem_addr), 32'h0000);
        chk("wrap_rdata1", 32'(fb_rdata), 32'hBEE1);
        @(negedge clk); #1;
        chk("wrap_done", 32'({fb_done, fb_rdata}), {15'd0, 1'b1, 16'hBEE2});

        // zero length yields a single word
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'h0103; fb_len = 6'd0; #1;
        chk("len0_gnt", 32'(fb_gnt), 32'd1);
        @(negedge clk); idle_inputs(); #1;
        chk("len0_done", 32'({fb_rvalid, fb_done, fb_rdata}), {14'd0, 2'b11, 16'hA003});
        chk("len0_back_idle", 32'(mem_addr), 32'd0);

        // over-long length is clamped to the maximum burst
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'h0500; fb_len = 6'd40; #1;
        done_at = -1;
        for (int i = 1; i <= 50 && done_at < 0; i++) begin
            @(negedge clk); idle_inputs(); #1;
            if (fb_done) done_at = i;
        end
        chk("clamp_len", 32'(done_at), 32'd32);

        // reset on the 3rd word of a 6-word burst
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'h0100; fb_len = 6'd6; #1;
        chk("rst_b_gnt", 32'(fb_gnt), 32'd1);
        @(negedge clk); idle_inputs();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; #1;
        chk("rst_outputs_zero", 32'(any_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rst_no_fb", 32'({fb_rvalid, fb_done}), 32'd0);
        end
        @(negedge clk);
        fb_req = 1'b1; fb_addr = 16'hF000; fb_len = 6'd2; #1;
        chk("post_rst_gnt", 32'(fb_gnt), 32'd1);
        @(negedge clk); idle_inputs(); #1;
        chk("post_rst_w0", 32'({fb_rvalid, fb_done, fb_rdata}), {14'd0, 2'b10, 16'h0064});
        @(negedge clk); #1;
        chk("post_rst_w1", 32'({fb_rvalid, fb_done, fb_rdata}), {14'd0, 2'b11, 16'h41F4});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
